umul_share_ctrl: RTL and testbench
==================================

Name: umul_share_ctrl

Overview:
- Sequencer/arbiter that shares one locked 8-bit underdesigned multiplier (combinational, 32-bit key input) between two requesters.
- Owns the key register, loaded serially MSB-first. Drives the multiplier operands and key.
- Waits a programmable settle time, captures the product and returns it over a valid/ready response channel tagged with the requester id.
- Sits between the requesters and the locked multiplier instance. The multiplier itself is external.

Parameters:
- OP_W, 8, operand width per multiplier input.
- RES_W, 16, product width (must equal 2*OP_W).
- KEY_W, 32, key width of the locked multiplier.
- SETTLE_CYC, 2, cycles between operand drive and result capture; legal range 1..15.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- key_sdata_i  in  1  serial key bit, MSB first.
- key_sen_i  in  1  shift enable for key_sdata_i.
- key_ready_o  out  1  full key loaded; multiplier usable.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester accept; one-hot or zero.
- req_a_i  in  2*OP_W  operand A; requester i uses bits [i*OP_W +: OP_W].
- req_b_i  in  2*OP_W  operand B, same packing as req_a_i.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  1  requester index of the response.
- rsp_result_o  out  RES_W  captured product.
- mul_op1_o  out  OP_W  to multiplier operand1.
- mul_op2_o  out  OP_W  to multiplier operand2.
- mul_key_o  out  KEY_W  to multiplier keyinput.
- mul_result_i  in  RES_W  from multiplier result.

Behaviour:
- Reset (async, immediate):
  - state=KEYLOAD; key_reg=0; bit_cnt=0; key_ready_o=0.
  - mul_op1_o/mul_op2_o=0; rsp_valid_o=0; rsp_id_o=0; rsp_result_o=0.
  - last_grant=1, so requester 0 has first priority.
  - A reset in any state aborts any in-flight operation with no response. The key must be reloaded.
- mul_key_o = key_ready_o ? key_reg : 0. A partial key is never exposed.
- State KEYLOAD:
  - On each key_sen_i: key_reg={key_reg[KEY_W-2:0],key_sdata_i}, bit_cnt+1.
  - At the edge where bit_cnt reaches KEY_W: key_ready_o=1 from the next cycle, bit_cnt cleared, go IDLE.
- State IDLE:
  - key_sen_i=1: clear bit_cnt, drop key_ready_o, perform the shift, go KEYLOAD. Key reload has priority over requests in the same cycle; req_ready_o=0.
  - Otherwise, if any req_valid_i, grant round-robin: the requester != last_grant wins a tie, else whichever is valid.
  - req_ready_o[g] = combinational, high only in IDLE with key_ready_o=1 and no key_sen_i.
  - On the accept edge: mul_op1_o=req_a_i[g], mul_op2_o=req_b_i[g], rsp_id_o=g, last_grant=g, wait_cnt=SETTLE_CYC-1, go WAIT.
- State WAIT:
  - wait_cnt!=0: decrement.
  - wait_cnt==0: rsp_result_o=mul_result_i, rsp_valid_o=1, go RESP.
  - Result is visible SETTLE_CYC cycles after the accept edge.
  - key_sen_i is ignored.
- State RESP:
  - rsp_valid_o, rsp_id_o and rsp_result_o are held stable until rsp_ready_i.
  - On rsp_valid_o&&rsp_ready_i: rsp_valid_o=0, go IDLE.
  - No new accept in the handshake cycle, so the minimum request spacing is SETTLE_CYC+2 cycles.
  - key_sen_i is ignored.
  - mul_op1_o/mul_op2_o hold their last values outside WAIT.
- No arithmetic in the block; the product width comes from mul_result_i.
- bit_cnt width = clog2(KEY_W+1). wait_cnt is 4 bits.

Test Plan:
1. Key load: reset, shift 0xBF3B33CC MSB-first over 32 key_sen_i cycles -> key_ready_o=1 the cycle after the 32nd shift; mul_key_o=0xBF3B33CC; mul_key_o=0 throughout the load.
2. Single request: requester 0 sends A=0x29, B=0x7A; the bench multiplier model returns the exact product -> req_ready_o=2'b01 for one cycle; rsp_valid_o exactly SETTLE_CYC cycles later; rsp_id_o=0; rsp_result_o=0x138A.
3. Contention: both requesters valid, 0:(0x11,0x11) and 1:(0x81,0x1C); rsp_ready_i tied 1 -> requester 0 served first with 0x0121, then requester 1 with 0x0E1C; a repeated tie alternates grants.
4. Backpressure: rsp_ready_i held 0 for 5 cycles while requester 1 stays valid -> rsp_valid_o, rsp_result_o and rsp_id_o stable; req_ready_o=0 until one cycle after the response handshake.
5. Key reload: key_sen_i asserted during WAIT -> ignored and the response completes. Then asserted in IDLE with a request pending -> key_ready_o drops, no accept, mul_key_o=0 until 32 new bits are loaded.
6. Reset mid-operation: assert rst_i in WAIT -> immediately rsp_valid_o=0, key_ready_o=0, mul_key_o=0, req_ready_o=0. After the reload, a request for 0x80x0x80 returns 0x4000.

Source files
------------

// File: rtl/umul_share_ctrl_if.sv
// Request/response channel between the requesters and the shared multiplier sequencer.
// The controller uses the slave modport and the requester side uses the master modport.
interface umul_share_ctrl_if #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned RES_W = 16
);
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [2*OP_W-1:0] req_a_i;
  logic [2*OP_W-1:0] req_b_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_id_o;
  logic [RES_W-1:0]  rsp_result_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );
endinterface

// File: rtl/umul_share_ctrl.sv
// Shares one key-locked combinational multiplier between two requesters: serial key load,
// round-robin grant, programmable settle delay, then a held valid/ready response.
module umul_share_ctrl #(
  parameter int unsigned OP_W       = 8,
  parameter int unsigned RES_W      = 16,
  parameter int unsigned KEY_W      = 32,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_sdata_i,
  input  logic              key_sen_i,
  output logic              key_ready_o,
  umul_share_ctrl_if.slave  bus,
  output logic [OP_W-1:0]   mul_op1_o,
  output logic [OP_W-1:0]   mul_op2_o,
  output logic [KEY_W-1:0]  mul_key_o,
  input  logic [RES_W-1:0]  mul_result_i
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    S_KEYLOAD = 2'd0,
    S_IDLE    = 2'd1,
    S_WAIT    = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             r_key_ready, w_key_ready_nxt;
  logic [OP_W-1:0]  r_op1, w_op1_nxt;
  logic [OP_W-1:0]  r_op2, w_op2_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic             r_rsp_id, w_rsp_id_nxt;
  logic [RES_W-1:0] r_rsp_result, w_rsp_result_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic [3:0]       r_wait_cnt, w_wait_cnt_nxt;

  logic             w_grant;
  logic             w_accept;
  logic [KEY_W-1:0] w_key_shifted;

  // On a tie the requester that was not served last wins; otherwise the single valid one.
  always_comb begin
    if (bus.req_valid_i == 2'b11) w_grant = ~r_last_grant;
    else                          w_grant = bus.req_valid_i[1];
  end

  assign w_accept      = (r_state == S_IDLE) && r_key_ready && !key_sen_i && (|bus.req_valid_i);
  assign w_key_shifted = {r_key[KEY_W-2:0], key_sdata_i};

  assign bus.req_ready_o  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_id_o     = r_rsp_id;
  assign bus.rsp_result_o = r_rsp_result;
  assign key_ready_o      = r_key_ready;
  assign mul_op1_o        = r_op1;
  assign mul_op2_o        = r_op2;
  assign mul_key_o        = r_key_ready ? r_key : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_KEYLOAD;
      r_key        <= '0;
      r_bit_cnt    <= '0;
      r_key_ready  <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_key        <= w_key_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_key_ready  <= w_key_ready_nxt;
      r_op1        <= w_op1_nxt;
      r_op2        <= w_op2_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_key_nxt        = r_key;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_key_ready_nxt  = r_key_ready;
    w_op1_nxt        = r_op1;
    w_op2_nxt        = r_op2;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_id_nxt     = r_rsp_id;
    w_rsp_result_nxt = r_rsp_result;
    w_last_grant_nxt = r_last_grant;
    w_wait_cnt_nxt   = r_wait_cnt;

    unique case (r_state)
      S_KEYLOAD: begin
        if (key_sen_i) begin
          w_key_nxt = w_key_shifted;
          if (r_bit_cnt == CNT_W'(KEY_W - 1)) begin
            w_bit_cnt_nxt   = '0;
            w_key_ready_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end

      S_IDLE: begin
        // A reload shift taken here is the first bit of the new key.
        if (key_sen_i) begin
          w_key_nxt       = w_key_shifted;
          w_bit_cnt_nxt   = CNT_W'(1);
          w_key_ready_nxt = 1'b0;
          w_state_nxt     = S_KEYLOAD;
        end else if (w_accept) begin
          w_op1_nxt        = w_grant ? bus.req_a_i[2*OP_W-1:OP_W] : bus.req_a_i[OP_W-1:0];
          w_op2_nxt        = w_grant ? bus.req_b_i[2*OP_W-1:OP_W] : bus.req_b_i[OP_W-1:0];
          w_rsp_id_nxt     = w_grant;
          w_last_grant_nxt = w_grant;
          w_wait_cnt_nxt   = 4'(SETTLE_CYC - 1);
          w_state_nxt      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_wait_cnt != 4'd0) begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end else begin
          w_rsp_result_nxt = mul_result_i;
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = S_RESP;
        end
      end

      S_RESP: begin
        if (r_rsp_valid && bus.rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: w_state_nxt = S_KEYLOAD;
    endcase
  end

endmodule

// File: tb/tb_umul_share_ctrl.sv
// Directed bench for umul_share_ctrl with an exact-product multiplier model.
module tb_umul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_sdata;
  logic        key_sen;
  logic        key_ready;
  logic [7:0]  mul_op1;
  logic [7:0]  mul_op2;
  logic [31:0] mul_key;
  logic [15:0] mul_result;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] KEY1 = 32'hBF3B33CC;
  localparam logic [31:0] KEY2 = 32'h12345678;

  umul_share_ctrl_if #(.OP_W(8), .RES_W(16)) bus ();

  umul_share_ctrl #(
    .OP_W(8), .RES_W(16), .KEY_W(32), .SETTLE_CYC(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .key_sdata_i(key_sdata), .key_sen_i(key_sen),
    .key_ready_o(key_ready), .bus(bus), .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
    .mul_key_o(mul_key), .mul_result_i(mul_result)
  );

  assign mul_result = {8'h00, mul_op1} * {8'h00, mul_op2};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts k[start..0]; during the load the key must stay hidden.
  task automatic load_key(input logic [31:0] k, input int start);
    for (int i = start; i >= 0; i--) begin
      key_sen = 1'b1;
      key_sdata = k[i];
      tick();
      if (i != 0) begin
        checks++;
        if (key_ready !== 1'b0 || mul_key !== 32'h0 || bus.req_ready_o !== 2'b00) begin
          failures++;
          $display("FAIL keyload_hidden bit=%0d: got rdy=%b key=%h req_ready=%b expected 0/0/00",
                   i, key_ready, mul_key, bus.req_ready_o);
        end
      end
    end
    key_sen = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || mul_key !== k) begin
      failures++;
      $display("FAIL keyload_done: got rdy=%b key=%h expected 1/%h", key_ready, mul_key, k);
    end
  endtask

  task automatic reset_and_load();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    load_key(KEY1, 31);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 2'b11;
    #1;
    checks++;
    if (key_ready !== 1'b0 || mul_key !== 32'h0 || bus.rsp_valid_o !== 1'b0 ||
        bus.rsp_id_o !== 1'b0 || bus.rsp_result_o !== 16'h0 || mul_op1 !== 8'h0 ||
        mul_op2 !== 8'h0 || bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b key=%h rv=%b id=%b res=%h op1=%h op2=%h rr=%b expected all zero",
               key_ready, mul_key, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o,
               mul_op1, mul_op2, bus.req_ready_o);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.req_valid_i = 2'b00;
    tick();
    checks++;
    if (key_ready !== 1'b0 || bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle: got rdy=%b rr=%b expected 0/00", key_ready, bus.req_ready_o);
    end
  endtask

  task automatic test_key_load();
    load_key(KEY1, 31);
  endtask

  task automatic test_single();
    bus.req_valid_i = 2'b01;
    bus.req_a_i = 16'h0029;
    bus.req_b_i = 16'h007A;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: got %b expected 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 1'b0 || mul_op1 !== 8'h29 || mul_op2 !== 8'h7A) begin
      failures++;
      $display("FAIL single_accept: got rr=%b rv=%b op1=%h op2=%h expected 00/0/29/7a",
               bus.req_ready_o, bus.rsp_valid_o, mul_op1, mul_op2);
    end
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid: got %b expected 0", bus.rsp_valid_o);
    end
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_result_o !== 16'h138A) begin
      failures++;
      $display("FAIL single_rsp: got rv=%b id=%b res=%h expected 1/0/138a",
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_handshake: got rv=%b expected 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_contention();
    reset_and_load();
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 2'b11;
    bus.req_a_i = 16'h8111;
    bus.req_b_i = 16'h1C11;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL tie_first_grant: got %b expected 01", bus.req_ready_o);
    end
    tick();
    checks++;
    if (bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL tie_busy: got %b expected 00", bus.req_ready_o);
    end
    tick();
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_result_o !== 16'h0121) begin
      failures++;
      $display("FAIL tie_rsp0: got rv=%b id=%b res=%h expected 1/0/0121",
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o);
    end
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL tie_second_grant: got rv=%b rr=%b expected 0/10", bus.rsp_valid_o, bus.req_ready_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b1 || bus.rsp_result_o !== 16'h0E1C) begin
      failures++;
      $display("FAIL tie_rsp1: got rv=%b id=%b res=%h expected 1/1/0e1c",
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o);
    end
    tick();
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL tie_alternate: got %b expected 01", bus.req_ready_o);
    end
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.req_valid_i = 2'b10;
    bus.req_a_i = 16'h0F00;
    bus.req_b_i = 16'h0D00;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL bp_grant: got %b expected 10", bus.req_ready_o);
    end
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b1 || bus.rsp_result_o !== 16'h00C3 ||
          bus.req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d: got rv=%b id=%b res=%h rr=%b expected 1/1/00c3/00",
                 i, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.req_ready_o);
      end
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL bp_handshake_cycle: got rr=%b expected 00", bus.req_ready_o);
    end
    tick();
    bus.rsp_ready_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL bp_after: got rv=%b rr=%b expected 0/10", bus.rsp_valid_o, bus.req_ready_o);
    end
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_key_reload();
    bus.req_valid_i = 2'b01;
    bus.req_a_i = 16'h0003;
    bus.req_b_i = 16'h0005;
    tick();
    bus.req_valid_i = 2'b00;
    key_sen = 1'b1;
    key_sdata = 1'b1;
    tick();
    tick();
    key_sen = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 16'h000F || key_ready !== 1'b1 || mul_key !== KEY1) begin
      failures++;
      $display("FAIL reload_in_wait: got rv=%b res=%h rdy=%b key=%h expected 1/000f/1/%h",
               bus.rsp_valid_o, bus.rsp_result_o, key_ready, mul_key, KEY1);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 2'b01;
    key_sen = 1'b1;
    key_sdata = KEY2[31];
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL reload_priority: got rr=%b expected 00", bus.req_ready_o);
    end
    tick();
    checks++;
    if (key_ready !== 1'b0 || mul_key !== 32'h0) begin
      failures++;
      $display("FAIL reload_drop: got rdy=%b key=%h expected 0/0", key_ready, mul_key);
    end
    load_key(KEY2, 30);
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL reload_resume: got rr=%b expected 01", bus.req_ready_o);
    end
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = 2'b01;
    bus.req_a_i = 16'h0080;
    bus.req_b_i = 16'h0080;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || key_ready !== 1'b0 || mul_key !== 32'h0 ||
        bus.req_ready_o !== 2'b00 || mul_op1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: got rv=%b rdy=%b key=%h rr=%b op1=%h expected 0/0/0/00/00",
               bus.rsp_valid_o, key_ready, mul_key, bus.req_ready_o, mul_op1);
    end
    #2;
    rst = 1'b0;
    bus.req_valid_i = 2'b00;
    tick();
    load_key(KEY1, 31);
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    tick();
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_result_o !== 16'h4000) begin
      failures++;
      $display("FAIL reset_recover: got rv=%b id=%b res=%h expected 1/0/4000",
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_sdata = 1'b0;
    key_sen = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.req_a_i = 16'h0;
    bus.req_b_i = 16'h0;
    bus.rsp_ready_i = 1'b0;
    tick();
    test_reset();
    test_key_load();
    test_single();
    test_contention();
    test_backpressure();
    test_key_reload();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
